// File: rtl/wall_draw_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wall_draw_ctrl_if
// Description : Bundles the request (start, wall_x, hole_y), the VGA pixel
//               stream (vga_x, vga_y, colour, plot) and the status outputs
//               (busy, done) of the wall draw controller.
//               The master is the game FSM. The slave is the draw controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface wall_draw_ctrl_if;
    logic       start;
    logic [7:0] wall_x;
    logic [6:0] hole_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output start, wall_x, hole_y,
        input  vga_x, vga_y, colour, plot, busy, done
    );

    modport slave (
        input  start, wall_x, hole_y,
        output vga_x, vga_y, colour, plot, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/wall_draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wall_draw_ctrl
// Description : For each frame, erases the wall strip at the previous x and
//               then draws the wall strip at the new x. The rows of the hole
//               are not plotted. The controller emits one pixel per cycle and
//               registers the pixel outputs. Pixels at or beyond SCREEN_W are
//               clipped but still take their cycle, so the length of a frame
//               is fixed.
// Revision    : 1.0 - initial release
// ============================================================================
module wall_draw_ctrl #(
    parameter int         WALL_WIDTH  = 4,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter int         HOLE_HEIGHT = 50,
    parameter logic [2:0] WALL_COLOUR = 3'b010,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter int         X_INIT      = 160
) (
    input  wire logic            clk,
    input  wire logic            resetn,
    wall_draw_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // The column counter needs at least one bit, even for a one-pixel wall.
    localparam int               CXW        = (WALL_WIDTH > 1) ? $clog2(WALL_WIDTH) : 1;
    localparam logic [CXW-1:0]   c_cx_last  = CXW'(WALL_WIDTH - 1);
    localparam logic [6:0]       c_cy_last  = 7'(SCREEN_H - 1);
    localparam logic [8:0]       c_screen_w = 9'(SCREEN_W);
    localparam logic [7:0]       c_hole_h   = 8'(HOLE_HEIGHT);

    state_t         r_state;
    logic [CXW-1:0] r_cx;
    logic [6:0]     r_cy;
    logic [7:0]     r_prev_x;
    logic [7:0]     r_cur_x;
    logic [6:0]     r_cur_hole;
    logic [7:0]     r_vga_x;
    logic [6:0]     r_vga_y;
    logic [2:0]     r_colour;
    logic           r_plot;
    logic           r_busy;
    logic           r_done;

    state_t         w_state_nx;
    logic [CXW-1:0] w_cx_nx;
    logic [6:0]     w_cy_nx;
    logic [CXW-1:0] w_cx_step;
    logic [6:0]     w_cy_step;
    logic           w_scan_last;
    logic           w_emit;
    logic           w_emit_draw;
    logic           w_busy_nx;
    logic           w_done_nx;
    logic           w_latch;
    logic           w_commit;
    logic [7:0]     w_base;
    logic [8:0]     w_px;
    logic [7:0]     w_hole_end;
    logic           w_in_hole;
    logic           w_plot_nx;
    logic [2:0]     w_colour_nx;
    logic [7:0]     w_vga_x_nx;
    logic [6:0]     w_vga_y_nx;

    // The hole bottom is computed in 8 bits so that a hole near the bottom
    // edge clamps at the bottom instead of wrapping to the top rows.
    assign w_hole_end = {1'b0, r_cur_hole} + c_hole_h;

    // Next-state logic, the scan counter step, and the pixel that is loaded
    // into the output registers on the next edge.
    always_comb begin
        w_state_nx  = r_state;
        w_cx_nx     = r_cx;
        w_cy_nx     = r_cy;
        w_emit      = 1'b0;
        w_emit_draw = 1'b0;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_latch     = 1'b0;
        w_commit    = 1'b0;

        w_scan_last = (r_cx == c_cx_last) && (r_cy == c_cy_last);
        if (r_cx == c_cx_last) begin
            w_cx_step = '0;
            w_cy_step = (r_cy == c_cy_last) ? 7'd0 : r_cy + 7'd1;
        end else begin
            w_cx_step = r_cx + 1'b1;
            w_cy_step = r_cy;
        end

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nx = S_ERASE;
                    w_cx_nx    = '0;
                    w_cy_nx    = '0;
                    w_emit     = 1'b1;
                    w_busy_nx  = 1'b1;
                    w_latch    = 1'b1;
                end
            end
            S_ERASE: begin
                w_cx_nx = w_cx_step;
                w_cy_nx = w_cy_step;
                w_emit  = 1'b1;
                if (w_scan_last) begin
                    w_state_nx  = S_DRAW;
                    w_emit_draw = 1'b1;
                end
            end
            S_DRAW: begin
                w_cx_nx = w_cx_step;
                w_cy_nx = w_cy_step;
                if (w_scan_last) begin
                    w_state_nx = S_DONE;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                    w_commit   = 1'b1;
                end else begin
                    w_emit      = 1'b1;
                    w_emit_draw = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Erase pixels use the previous x. Draw pixels use the latched x.
        w_base      = w_emit_draw ? r_cur_x : r_prev_x;
        w_px        = {1'b0, w_base} + 9'(w_cx_nx);
        w_in_hole   = w_emit_draw && (w_cy_nx >= r_cur_hole) &&
                      ({1'b0, w_cy_nx} < w_hole_end);
        w_plot_nx   = w_emit && (w_px < c_screen_w) && !w_in_hole;
        w_colour_nx = w_emit_draw ? WALL_COLOUR : BG_COLOUR;
        w_vga_x_nx  = w_emit ? w_px[7:0] : 8'd0;
        w_vga_y_nx  = w_emit ? w_cy_nx : 7'd0;
    end

    // State register and scan counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cx    <= w_cx_nx;
            r_cy    <= w_cy_nx;
        end
    end

    // Frame parameters. They are captured when start is accepted, and the
    // previous x is committed when the frame completes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prev_x   <= 8'(X_INIT);
            r_cur_x    <= '0;
            r_cur_hole <= '0;
        end else begin
            if (w_latch) begin
                r_cur_x    <= bus.wall_x;
                r_cur_hole <= bus.hole_y;
            end
            if (w_commit) begin
                r_prev_x <= r_cur_x;
            end
        end
    end

    // Registered pixel stream and status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vga_x  <= '0;
            r_vga_y  <= '0;
            r_colour <= BG_COLOUR;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_vga_x  <= w_vga_x_nx;
            r_vga_y  <= w_vga_y_nx;
            r_colour <= w_colour_nx;
            r_plot   <= w_plot_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
        end
    end

    assign bus.vga_x  = r_vga_x;
    assign bus.vga_y  = r_vga_y;
    assign bus.colour = r_colour;
    assign bus.plot   = r_plot;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule
`default_nettype wire
